// File: rtl/n_term_pkg.sv
// Shared constants for the north-edge 1-segment turnaround tile.
// No logic, so no latency or backpressure.
// Wire indices follow the fabric letter order A,B,C,D,F,G,H,I.
package n_term_pkg;

    localparam int NUM_WIRES = 16;

    localparam int WIRE_NA_1S0 = 0;
    localparam int WIRE_NA_1S1 = 1;
    localparam int WIRE_NB_1S0 = 2;
    localparam int WIRE_NB_1S1 = 3;
    localparam int WIRE_NC_1S0 = 4;
    localparam int WIRE_NC_1S1 = 5;
    localparam int WIRE_ND_1S0 = 6;
    localparam int WIRE_ND_1S1 = 7;
    localparam int WIRE_NF_1S0 = 8;
    localparam int WIRE_NF_1S1 = 9;
    localparam int WIRE_NG_1S0 = 10;
    localparam int WIRE_NG_1S1 = 11;
    localparam int WIRE_NH_1S0 = 12;
    localparam int WIRE_NH_1S1 = 13;
    localparam int WIRE_NI_1S0 = 14;
    localparam int WIRE_NI_1S1 = 15;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_REG    = 2'b01,
        MODE_TIE0   = 2'b10,
        MODE_LFSR   = 2'b11
    } mode_e;

endpackage

// File: rtl/n_term_s1_turnaround_if.sv
// Bundle of configuration frame and turnaround wires, indexed by wire number.
// No logic, so no latency or backpressure.
// master drives frame and north-going wires; slave returns south-going wires.
interface n_term_s1_turnaround_if;
    import n_term_pkg::*;

    logic [31:0]          frame_data;
    logic                 frame_strobe;
    logic [NUM_WIRES-1:0] from_n;
    logic [NUM_WIRES-1:0] to_s;

    modport master (output frame_data, frame_strobe, from_n, input to_s);
    modport slave  (input frame_data, frame_strobe, from_n, output to_s);

endinterface

// File: rtl/n_term_lfsr16.sv
// Free-running 16-bit Galois LFSR used as an edge-routing test pattern.
// Advances one step per clock; reset loads SEED.
// No backpressure: runs every cycle regardless of configuration.
module n_term_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("n_term_lfsr16: SEED must be nonzero, an all-zero LFSR never leaves zero");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ TAPS;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    // A maximal-length polynomial from a nonzero seed can never hit the lock-up state.
    assert property (@(posedge clk) disable iff (rst) lfsr != 16'h0000);

endmodule

// File: rtl/n_term_s1_turnaround.sv
// North-edge terminal: turns 16 north-going 1-seg wires back south, per-wire mode.
// Bypass is zero latency, registered mode is one cycle; mode changes land the cycle after strobe.
// No backpressure: pure wire fabric, every input sampled every cycle.
module n_term_s1_turnaround
    import n_term_pkg::*;
#(
    parameter int          NoConfigBits = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS    = 16'hB400
) (
    input  logic                    UserCLK,
    input  logic                    RST,
    input  logic [NoConfigBits-1:0] FrameData,
    input  logic                    FrameStrobe,
    input  logic from_NA_1s0, input  logic from_NA_1s1,
    input  logic from_NB_1s0, input  logic from_NB_1s1,
    input  logic from_NC_1s0, input  logic from_NC_1s1,
    input  logic from_ND_1s0, input  logic from_ND_1s1,
    input  logic from_NF_1s0, input  logic from_NF_1s1,
    input  logic from_NG_1s0, input  logic from_NG_1s1,
    input  logic from_NH_1s0, input  logic from_NH_1s1,
    input  logic from_NI_1s0, input  logic from_NI_1s1,
    output logic to_SA_1s0,   output logic to_SA_1s1,
    output logic to_SB_1s0,   output logic to_SB_1s1,
    output logic to_SC_1s0,   output logic to_SC_1s1,
    output logic to_SD_1s0,   output logic to_SD_1s1,
    output logic to_SF_1s0,   output logic to_SF_1s1,
    output logic to_SG_1s0,   output logic to_SG_1s1,
    output logic to_SH_1s0,   output logic to_SH_1s1,
    output logic to_SI_1s0,   output logic to_SI_1s1
);

    logic [NoConfigBits-1:0] mode;
    logic [NUM_WIRES-1:0]    from_n;
    logic [NUM_WIRES-1:0]    to_s;
    logic [NUM_WIRES-1:0]    pipe;
    logic [15:0]             lfsr;

    assign from_n = {from_NI_1s1, from_NI_1s0, from_NH_1s1, from_NH_1s0,
                     from_NG_1s1, from_NG_1s0, from_NF_1s1, from_NF_1s0,
                     from_ND_1s1, from_ND_1s0, from_NC_1s1, from_NC_1s0,
                     from_NB_1s1, from_NB_1s0, from_NA_1s1, from_NA_1s0};

    assign {to_SI_1s1, to_SI_1s0, to_SH_1s1, to_SH_1s0,
            to_SG_1s1, to_SG_1s0, to_SF_1s1, to_SF_1s0,
            to_SD_1s1, to_SD_1s0, to_SC_1s1, to_SC_1s0,
            to_SB_1s1, to_SB_1s0, to_SA_1s1, to_SA_1s0} = to_s;

    // pipe samples unconditionally so switching into registered mode never shows stale data.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            mode <= '0;
            pipe <= '0;
        end else begin
            if (FrameStrobe) begin
                mode <= FrameData;
            end
            pipe <= from_n;
        end
    end

    n_term_lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk  (UserCLK),
        .rst  (RST),
        .lfsr (lfsr)
    );

    for (genvar k = 0; k < NUM_WIRES; k++) begin : g_wire
        mode_e wire_mode;
        logic  wire_out;

        assign wire_mode = mode_e'(mode[2*k +: 2]);

        always_comb begin
            wire_out = from_n[k];
            case (wire_mode)
                MODE_BYPASS: wire_out = from_n[k];
                MODE_REG:    wire_out = pipe[k];
                MODE_TIE0:   wire_out = 1'b0;
                MODE_LFSR:   wire_out = lfsr[k];
                default:     wire_out = from_n[k];
            endcase
        end

        assign to_s[k] = wire_out;
    end

endmodule

// File: tb/tb_n_term_s1_turnaround.sv
// Directed bench for the north-edge 1-seg turnaround tile.
// Drives and samples 1 time unit after the rising edge of UserCLK.
module tb_n_term_s1_turnaround;

    logic UserCLK;
    logic RST;

    n_term_s1_turnaround_if bus ();

    int n_checks = 0;
    int n_errors = 0;

    n_term_s1_turnaround dut (
        .UserCLK     (UserCLK),
        .RST         (RST),
        .FrameData   (bus.frame_data),
        .FrameStrobe (bus.frame_strobe),
        .from_NA_1s0 (bus.from_n[0]),  .from_NA_1s1 (bus.from_n[1]),
        .from_NB_1s0 (bus.from_n[2]),  .from_NB_1s1 (bus.from_n[3]),
        .from_NC_1s0 (bus.from_n[4]),  .from_NC_1s1 (bus.from_n[5]),
        .from_ND_1s0 (bus.from_n[6]),  .from_ND_1s1 (bus.from_n[7]),
        .from_NF_1s0 (bus.from_n[8]),  .from_NF_1s1 (bus.from_n[9]),
        .from_NG_1s0 (bus.from_n[10]), .from_NG_1s1 (bus.from_n[11]),
        .from_NH_1s0 (bus.from_n[12]), .from_NH_1s1 (bus.from_n[13]),
        .from_NI_1s0 (bus.from_n[14]), .from_NI_1s1 (bus.from_n[15]),
        .to_SA_1s0   (bus.to_s[0]),    .to_SA_1s1   (bus.to_s[1]),
        .to_SB_1s0   (bus.to_s[2]),    .to_SB_1s1   (bus.to_s[3]),
        .to_SC_1s0   (bus.to_s[4]),    .to_SC_1s1   (bus.to_s[5]),
        .to_SD_1s0   (bus.to_s[6]),    .to_SD_1s1   (bus.to_s[7]),
        .to_SF_1s0   (bus.to_s[8]),    .to_SF_1s1   (bus.to_s[9]),
        .to_SG_1s0   (bus.to_s[10]),   .to_SG_1s1   (bus.to_s[11]),
        .to_SH_1s0   (bus.to_s[12]),   .to_SH_1s1   (bus.to_s[13]),
        .to_SI_1s0   (bus.to_s[14]),   .to_SI_1s1   (bus.to_s[15])
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge UserCLK);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    logic [15:0] model;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST              = 1'b1;
        bus.frame_data   = '0;
        bus.frame_strobe = 1'b0;
        bus.from_n       = '0;
        step();
        step();
        chk("reset_lfsr_seed", {16'h0, dut.lfsr}, 32'h0000_ACE1);
        chk("reset_out_zero",  {16'h0, bus.to_s}, 32'h0);
        RST = 1'b0;

        // Loopback default after reset.
        bus.from_n = 16'h8001;
        #1;
        chk("bypass_a0_i1", {16'h0, bus.to_s}, 32'h0000_8001);
        bus.from_n = 16'h5A3C;
        #1;
        chk("bypass_5a3c", {16'h0, bus.to_s}, 32'h0000_5A3C);

        // Wire 0 registered; input is 1 at the strobe edge.
        bus.from_n       = 16'h0001;
        bus.frame_data   = 32'h0000_0001;
        bus.frame_strobe = 1'b1;
        step();
        bus.frame_strobe = 1'b0;
        chk("reg_first_sample", {31'h0, bus.to_s[0]}, 32'h1);
        bus.from_n[0] = 1'b0;
        #1;
        chk("reg_no_comb", {31'h0, bus.to_s[0]}, 32'h1);
        bus.from_n[1] = 1'b1;
        #1;
        chk("reg_w1_bypass", {31'h0, bus.to_s[1]}, 32'h1);
        step();
        chk("reg_fall", {31'h0, bus.to_s[0]}, 32'h0);
        bus.from_n[0] = 1'b1;
        #1;
        chk("reg_hold_low", {31'h0, bus.to_s[0]}, 32'h0);
        step();
        chk("reg_rise", {31'h0, bus.to_s[0]}, 32'h1);

        // Wire 1 tied low, wire 0 back to bypass.
        bus.frame_data   = 32'h0000_0008;
        bus.frame_strobe = 1'b1;
        step();
        bus.frame_strobe = 1'b0;
        bus.from_n       = 16'h0003;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("tie0_w1", {31'h0, bus.to_s[1]}, 32'h0);
            step();
        end
        bus.from_n[0] = 1'b0;
        #1;
        chk("tie0_w0_bypass", {31'h0, bus.to_s[0]}, 32'h0);

        // Back-to-back strobes: 0x2 (wire 0 tie) then 0x4 (wire 1 registered).
        bus.from_n       = 16'h0003;
        bus.frame_data   = 32'h0000_0002;
        bus.frame_strobe = 1'b1;
        step();
        bus.frame_data   = 32'h0000_0004;
        step();
        bus.frame_strobe = 1'b0;
        chk("b2b_w0_bypass", {31'h0, bus.to_s[0]}, 32'h1);
        chk("b2b_w1_reg",    {31'h0, bus.to_s[1]}, 32'h1);
        bus.from_n = 16'h0000;
        #1;
        chk("b2b_w0_follow", {31'h0, bus.to_s[0]}, 32'h0);
        chk("b2b_w1_held",   {31'h0, bus.to_s[1]}, 32'h1);

        // Reset, then all-pattern one cycle later.
        RST = 1'b1;
        step();
        RST              = 1'b0;
        bus.from_n       = 16'h3C5A;
        bus.frame_data   = 32'hFFFF_FFFF;
        bus.frame_strobe = 1'b1;
        step();
        bus.frame_strobe = 1'b0;
        chk("lfsr_step1", {16'h0, bus.to_s}, 32'h0000_E270);
        bus.frame_data   = 32'h0000_0000;
        bus.frame_strobe = 1'b1;
        #1;
        chk("no_frame_comb", {16'h0, bus.to_s}, 32'h0000_E270);
        bus.frame_strobe = 1'b0;
        bus.frame_data   = 32'hFFFF_FFFF;
        step();
        chk("lfsr_step2", {16'h0, bus.to_s}, 32'h0000_7138);
        step();
        chk("lfsr_step3", {16'h0, bus.to_s}, 32'h0000_389C);
        model = 16'h389C;
        for (int i = 0; i < 100; i++) begin
            step();
            model = lfsr_next(model);
            bus.from_n = 16'(i * 16'h1357);
            #1;
            chk("lfsr_model", {16'h0, bus.to_s}, {16'h0, model});
        end

        // Mid-operation reset returns to bypass.
        bus.from_n = 16'h1234;
        RST        = 1'b1;
        step();
        chk("midrst_bypass", {16'h0, bus.to_s}, 32'h0000_1234);
        chk("midrst_lfsr",   {16'h0, dut.lfsr}, 32'h0000_ACE1);
        RST = 1'b0;
        bus.from_n = 16'hBEEF;
        #1;
        chk("midrst_follow", {16'h0, bus.to_s}, 32'h0000_BEEF);

        // Reset beats a simultaneous strobe.
        RST              = 1'b1;
        bus.frame_data   = 32'h5555_5555;
        bus.frame_strobe = 1'b1;
        step();
        RST              = 1'b0;
        bus.frame_strobe = 1'b0;
        bus.from_n       = 16'hA5A5;
        #1;
        chk("rst_wins_a5a5", {16'h0, bus.to_s}, 32'h0000_A5A5);
        step();
        bus.from_n = 16'h0F0F;
        #1;
        chk("rst_wins_0f0f", {16'h0, bus.to_s}, 32'h0000_0F0F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
